// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - 2-entry skid pipeline register with flush/NOP bubble; optional PIPE_STAGE_PERF_EN counters
`default_nettype none

module pipe_stage_reg #(
  parameter int unsigned           XLEN      = 32,
  parameter int unsigned           ILEN      = 32,
  parameter logic [ILEN-1:0]       NOP_INSTR = ILEN'(32'h0000_0013),
  parameter logic [XLEN-1:0]       RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            up_valid,
  output logic            up_ready,
  input  logic [XLEN-1:0] up_pc,
  input  logic [XLEN-1:0] up_pc_next,
  input  logic [ILEN-1:0] up_instr,
  output logic            dn_valid,
  input  logic            dn_ready,
  output logic [XLEN-1:0] dn_pc,
  output logic [XLEN-1:0] dn_pc_next,
  output logic [ILEN-1:0] dn_instr,
  output logic [1:0]      occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt
`endif
);

  // The state encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t            state_q, state_d;

  // Main entry: drives dn_* directly.
  logic [XLEN-1:0]   main_pc_q, main_pc_d;
  logic [XLEN-1:0]   main_pc_next_q, main_pc_next_d;
  logic [ILEN-1:0]   main_instr_q, main_instr_d;

  // Skid entry: catches the beat accepted while downstream stalls.
  logic [XLEN-1:0]   skid_pc_q, skid_pc_d;
  logic [XLEN-1:0]   skid_pc_next_q, skid_pc_next_d;
  logic [ILEN-1:0]   skid_instr_q, skid_instr_d;

  logic              up_xfer;
  logic              dn_xfer;

  // Handshake signals decode only the state flops, so there is no
  // combinational path from dn_ready to up_ready or from up_* to dn_*.
  assign up_ready   = (state_q != ST_SKID);
  assign dn_valid   = (state_q != ST_EMPTY);
  assign occupancy  = 2'(state_q);
  assign up_xfer    = up_valid & up_ready;
  assign dn_xfer    = dn_valid & dn_ready;

  // The instruction register is rewritten with NOP whenever the stage
  // empties, so dn_instr shows a bubble straight from a flop.
  assign dn_pc      = main_pc_q;
  assign dn_pc_next = main_pc_next_q;
  assign dn_instr   = main_instr_q;

  // Next-state and datapath load selection; flush overrides everything.
  always_comb begin
    state_d        = state_q;
    main_pc_d      = main_pc_q;
    main_pc_next_d = main_pc_next_q;
    main_instr_d   = main_instr_q;
    skid_pc_d      = skid_pc_q;
    skid_pc_next_d = skid_pc_next_q;
    skid_instr_d   = skid_instr_q;

    if (flush_i) begin
      // PCs keep their last values; only the instruction becomes a bubble.
      state_d      = ST_EMPTY;
      main_instr_d = NOP_INSTR;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (up_xfer) begin
            state_d        = ST_FULL;
            main_pc_d      = up_pc;
            main_pc_next_d = up_pc_next;
            main_instr_d   = up_instr;
          end
        end

        ST_FULL: begin
          unique case ({up_xfer, dn_xfer})
            2'b11: begin
              main_pc_d      = up_pc;
              main_pc_next_d = up_pc_next;
              main_instr_d   = up_instr;
            end
            2'b10: begin
              state_d        = ST_SKID;
              skid_pc_d      = up_pc;
              skid_pc_next_d = up_pc_next;
              skid_instr_d   = up_instr;
            end
            2'b01: begin
              state_d      = ST_EMPTY;
              main_instr_d = NOP_INSTR;
            end
            default: begin
            end
          endcase
        end

        ST_SKID: begin
          // up_ready is low here, so only a drain can happen.
          if (dn_xfer) begin
            state_d        = ST_FULL;
            main_pc_d      = skid_pc_q;
            main_pc_next_d = skid_pc_next_q;
            main_instr_d   = skid_instr_q;
          end
        end

        default: begin
          state_d      = ST_EMPTY;
          main_instr_d = NOP_INSTR;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Main and skid data registers; reset leaves both entries as a bubble at RESET_PC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_pc_q      <= RESET_PC;
      main_pc_next_q <= RESET_PC;
      main_instr_q   <= NOP_INSTR;
      skid_pc_q      <= RESET_PC;
      skid_pc_next_q <= RESET_PC;
      skid_instr_q   <= NOP_INSTR;
    end else begin
      main_pc_q      <= main_pc_d;
      main_pc_next_q <= main_pc_next_d;
      main_instr_q   <= main_instr_d;
      skid_pc_q      <= skid_pc_d;
      skid_pc_next_q <= skid_pc_next_d;
      skid_instr_q   <= skid_instr_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters: downstream stall cycles and flushes that discard beats.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (dn_valid && !dn_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (flush_i && (state_q != ST_EMPTY) && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg against a queue model
`timescale 1ns/1ps

module tb_pipe_stage_reg;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] RST_PC = 32'h0000_1000;

  logic        clk;
  logic        rst;
  logic        flush_i;
  logic        up_valid;
  logic        up_ready;
  logic [31:0] up_pc;
  logic [31:0] up_pc_next;
  logic [31:0] up_instr;
  logic        dn_valid;
  logic        dn_ready;
  logic [31:0] dn_pc;
  logic [31:0] dn_pc_next;
  logic [31:0] dn_instr;
  logic [1:0]  occupancy;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  int tests_run = 0;
  int fails     = 0;

  pipe_stage_reg #(
    .XLEN      (32),
    .ILEN      (32),
    .NOP_INSTR (NOP),
    .RESET_PC  (RST_PC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush_i),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_pc      (up_pc),
    .up_pc_next (up_pc_next),
    .up_instr   (up_instr),
    .dn_valid   (dn_valid),
    .dn_ready   (dn_ready),
    .dn_pc      (dn_pc),
    .dn_pc_next (dn_pc_next),
    .dn_instr   (dn_instr),
    .occupancy  (occupancy)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: FIFO of held beats (capacity 2) plus the beat last shown on dn_pc.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pcn;
    logic [31:0] instr;
  } beat_t;

  beat_t mq[$];
  beat_t shown;

  function automatic void model_reset();
    mq.delete();
    shown = '{pc: RST_PC, pcn: RST_PC, instr: NOP};
  endfunction

  function automatic void model_edge();
    int    n;
    beat_t b;
    n = mq.size();
    if (flush_i) begin
      mq.delete();
    end else begin
      if (n > 0 && dn_ready) void'(mq.pop_front());
      if (up_valid && n < 2) begin
        b = '{pc: up_pc, pcn: up_pc_next, instr: up_instr};
        mq.push_back(b);
      end
    end
    if (mq.size() > 0) shown = mq[0];
  endfunction

  task automatic drive_cycle(input logic v, input logic [31:0] pc, input logic [31:0] pcn,
                             input logic [31:0] instr, input logic r, input logic f);
    @(negedge clk);
    up_valid   = v;
    up_pc      = pc;
    up_pc_next = pcn;
    up_instr   = instr;
    dn_ready   = r;
    flush_i    = f;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b0;
    up_valid = 1'b0;
    dn_ready = 1'b0;
    flush_i  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    up_pc = '0; up_pc_next = '0; up_instr = '0;
    do_reset();
    tests_run++; if (dn_valid !== 1'b0) begin fails++; $display("FAIL reset_dn_valid got %b want 0", dn_valid); end
    tests_run++; if (up_ready !== 1'b1) begin fails++; $display("FAIL reset_up_ready got %b want 1", up_ready); end
    tests_run++; if (occupancy !== 2'd0) begin fails++; $display("FAIL reset_occ got %0d want 0", occupancy); end
    tests_run++; if (dn_pc !== RST_PC) begin fails++; $display("FAIL reset_dn_pc got %h want %h", dn_pc, RST_PC); end
    tests_run++; if (dn_pc_next !== RST_PC) begin fails++; $display("FAIL reset_dn_pc_next got %h want %h", dn_pc_next, RST_PC); end
    tests_run++; if (dn_instr !== NOP) begin fails++; $display("FAIL reset_dn_instr got %h want %h", dn_instr, NOP); end
  endtask

  task automatic test_stream();
    logic [31:0] pcs [3];
    logic [31:0] ins [3];
    pcs[0] = 32'h00; pcs[1] = 32'h04; pcs[2] = 32'h08;
    ins[0] = 32'hA;  ins[1] = 32'hB;  ins[2] = 32'hC;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, pcs[i], pcs[i] + 32'd4, ins[i], 1'b1, 1'b0);
      tests_run++; if (dn_valid !== 1'b1) begin fails++; $display("FAIL stream_valid[%0d] got %b want 1", i, dn_valid); end
      tests_run++; if (dn_pc !== pcs[i]) begin fails++; $display("FAIL stream_pc[%0d] got %h want %h", i, dn_pc, pcs[i]); end
      tests_run++; if (dn_pc_next !== pcs[i] + 32'd4) begin fails++; $display("FAIL stream_pcn[%0d] got %h want %h", i, dn_pc_next, pcs[i] + 32'd4); end
      tests_run++; if (dn_instr !== ins[i]) begin fails++; $display("FAIL stream_instr[%0d] got %h want %h", i, dn_instr, ins[i]); end
      tests_run++; if (occupancy !== 2'd1) begin fails++; $display("FAIL stream_occ[%0d] got %0d want 1", i, occupancy); end
      tests_run++; if (up_ready !== 1'b1) begin fails++; $display("FAIL stream_up_ready[%0d] got %b want 1", i, up_ready); end
    end
    drive_cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    tests_run++; if (dn_valid !== 1'b0) begin fails++; $display("FAIL stream_drain_valid got %b want 0", dn_valid); end
    tests_run++; if (dn_instr !== NOP) begin fails++; $display("FAIL stream_bubble_instr got %h want %h", dn_instr, NOP); end
    tests_run++; if (dn_pc !== 32'h08) begin fails++; $display("FAIL stream_hold_pc got %h want 00000008", dn_pc); end
  endtask

  task automatic test_backpressure();
    drive_cycle(1'b1, 32'h10, 32'h14, 32'h1010, 1'b0, 1'b0);
    tests_run++; if (occupancy !== 2'd1) begin fails++; $display("FAIL bp_occ1 got %0d want 1", occupancy); end
    tests_run++; if (up_ready !== 1'b1) begin fails++; $display("FAIL bp_ready1 got %b want 1", up_ready); end
    drive_cycle(1'b1, 32'h14, 32'h18, 32'h1014, 1'b0, 1'b0);
    tests_run++; if (occupancy !== 2'd2) begin fails++; $display("FAIL bp_occ2 got %0d want 2", occupancy); end
    tests_run++; if (up_ready !== 1'b0) begin fails++; $display("FAIL bp_ready2 got %b want 0", up_ready); end
    drive_cycle(1'b1, 32'h18, 32'h1C, 32'h1018, 1'b0, 1'b0);
    tests_run++; if (occupancy !== 2'd2) begin fails++; $display("FAIL bp_occ_held got %0d want 2", occupancy); end
    tests_run++; if (dn_pc !== 32'h10 || dn_instr !== 32'h1010) begin fails++; $display("FAIL bp_stable got %h/%h want 00000010/00001010", dn_pc, dn_instr); end
    drive_cycle(1'b1, 32'h18, 32'h1C, 32'h1018, 1'b1, 1'b0);
    tests_run++; if (dn_pc !== 32'h14 || dn_instr !== 32'h1014) begin fails++; $display("FAIL bp_second got %h/%h want 00000014/00001014", dn_pc, dn_instr); end
    tests_run++; if (occupancy !== 2'd1) begin fails++; $display("FAIL bp_occ_drain got %0d want 1", occupancy); end
    drive_cycle(1'b1, 32'h18, 32'h1C, 32'h1018, 1'b1, 1'b0);
    tests_run++; if (dn_pc !== 32'h18 || dn_instr !== 32'h1018 || dn_valid !== 1'b1) begin fails++; $display("FAIL bp_third got %h/%h v=%b want 00000018/00001018 v=1", dn_pc, dn_instr, dn_valid); end
    drive_cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    tests_run++; if (dn_valid !== 1'b0) begin fails++; $display("FAIL bp_empty got %b want 0", dn_valid); end
  endtask

  task automatic test_flush();
    drive_cycle(1'b1, 32'h30, 32'h34, 32'h3030, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h34, 32'h38, 32'h3034, 1'b0, 1'b0);
    tests_run++; if (occupancy !== 2'd2) begin fails++; $display("FAIL flush_prefill got %0d want 2", occupancy); end
    drive_cycle(1'b1, 32'h20, 32'h24, 32'h2020, 1'b0, 1'b1);
    tests_run++; if (dn_valid !== 1'b0) begin fails++; $display("FAIL flush_valid got %b want 0", dn_valid); end
    tests_run++; if (dn_instr !== NOP) begin fails++; $display("FAIL flush_instr got %h want %h", dn_instr, NOP); end
    tests_run++; if (occupancy !== 2'd0) begin fails++; $display("FAIL flush_occ got %0d want 0", occupancy); end
    tests_run++; if (up_ready !== 1'b1) begin fails++; $display("FAIL flush_up_ready got %b want 1", up_ready); end
    drive_cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    tests_run++; if (dn_valid !== 1'b0 || dn_pc !== 32'h30) begin fails++; $display("FAIL flush_dropped got v=%b pc=%h want v=0 pc=00000030", dn_valid, dn_pc); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc;
    drive_cycle(1'b1, 32'h40, 32'h44, 32'h4040, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      pc = 32'h44 + 32'(4 * i);
      drive_cycle(1'b1, pc, pc + 32'd4, pc ^ 32'hBEEF_0000, 1'b1, 1'b0);
      tests_run++; if (occupancy !== 2'd1 || up_ready !== 1'b1 || dn_valid !== 1'b1) begin fails++; $display("FAIL b2b_flow[%0d] got occ=%0d rdy=%b v=%b want occ=1 rdy=1 v=1", i, occupancy, up_ready, dn_valid); end
      tests_run++; if (dn_pc !== pc || dn_instr !== (pc ^ 32'hBEEF_0000)) begin fails++; $display("FAIL b2b_data[%0d] got %h/%h want %h/%h", i, dn_pc, dn_instr, pc, pc ^ 32'hBEEF_0000); end
    end
    drive_cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    drive_cycle(1'b1, 32'h50, 32'h54, 32'h5050, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h54, 32'h58, 32'h5054, 1'b0, 1'b0);
    tests_run++; if (occupancy !== 2'd2) begin fails++; $display("FAIL async_prefill got %0d want 2", occupancy); end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    model_reset();
    tests_run++; if (dn_valid !== 1'b0) begin fails++; $display("FAIL async_valid got %b want 0", dn_valid); end
    tests_run++; if (dn_pc !== RST_PC || dn_pc_next !== RST_PC) begin fails++; $display("FAIL async_pc got %h/%h want %h", dn_pc, dn_pc_next, RST_PC); end
    tests_run++; if (occupancy !== 2'd0 || up_ready !== 1'b1 || dn_instr !== NOP) begin fails++; $display("FAIL async_state got occ=%0d rdy=%b instr=%h want 0/1/%h", occupancy, up_ready, dn_instr, NOP); end
    up_valid = 1'b0;
    dn_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    drive_cycle(1'b1, 32'h60, 32'h64, 32'h6060, 1'b0, 1'b0);
    tests_run++; if (dn_valid !== 1'b1 || dn_pc !== 32'h60) begin fails++; $display("FAIL async_first_beat got v=%b pc=%h want v=1 pc=00000060", dn_valid, dn_pc); end
    drive_cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic        exp_v;
    logic [31:0] exp_instr;
    int          errs;
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      drive_cycle($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
      exp_v     = (mq.size() != 0);
      exp_instr = exp_v ? mq[0].instr : NOP;
      tests_run++; if (dn_valid !== exp_v) begin fails++; errs++; $display("FAIL rand_valid[%0d] got %b want %b", i, dn_valid, exp_v); end
      tests_run++; if (occupancy !== 2'(mq.size())) begin fails++; errs++; $display("FAIL rand_occ[%0d] got %0d want %0d", i, occupancy, mq.size()); end
      tests_run++; if (up_ready !== (mq.size() < 2)) begin fails++; errs++; $display("FAIL rand_up_ready[%0d] got %b want %b", i, up_ready, mq.size() < 2); end
      tests_run++; if (dn_pc !== shown.pc || dn_pc_next !== shown.pcn) begin fails++; errs++; $display("FAIL rand_pc[%0d] got %h/%h want %h/%h", i, dn_pc, dn_pc_next, shown.pc, shown.pcn); end
      tests_run++; if (dn_instr !== exp_instr) begin fails++; errs++; $display("FAIL rand_instr[%0d] got %h want %h", i, dn_instr, exp_instr); end
      if (errs > 20) break;
    end
  endtask

`ifdef PIPE_STAGE_PERF_EN
  task automatic test_perf();
    do_reset();
    tests_run++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin fails++; $display("FAIL perf_reset got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
    drive_cycle(1'b1, 32'h70, 32'h74, 32'h7070, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive_cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    drive_cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    tests_run++; if (stall_cnt !== 32'd5) begin fails++; $display("FAIL perf_stall got %0d want 5", stall_cnt); end
    tests_run++; if (flush_cnt !== 32'd1) begin fails++; $display("FAIL perf_flush got %0d want 1", flush_cnt); end
    drive_cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    tests_run++; if (flush_cnt !== 32'd1) begin fails++; $display("FAIL perf_flush_empty got %0d want 1", flush_cnt); end
  endtask
`endif

  initial begin
    rst        = 1'b0;
    flush_i    = 1'b0;
    up_valid   = 1'b0;
    dn_ready   = 1'b0;
    up_pc      = '0;
    up_pc_next = '0;
    up_instr   = '0;
    model_reset();
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_async_reset();
    test_random();
`ifdef PIPE_STAGE_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register carrying PC, next-PC and instruction between adjacent CPU stages (FETCH→DECODE, DECODE→EXECUTE, …). It replaces the bare per-stage flops with a 2-entry skid buffer that adds valid/ready flow control, synchronous flush and NOP bubble insertion. One instance sits at each stage boundary in the core.

Parameters:
XLEN, 32, width of pc and pc_next fields
ILEN, 32, instruction width
NOP_INSTR, 32'h0000_0013, instruction presented downstream when no valid beat is held (addi x0,x0,0); width ILEN
RESET_PC, 0, reset value of the dn_pc/dn_pc_next registers

Ports:
clk  input  1  stage clock; all state on rising edge
rst  input  1  asynchronous, active-low reset
flush_i  input  1  synchronous flush: discard all held and incoming beats
up_valid  input  1  upstream beat valid
up_ready  output  1  this stage can accept a beat
up_pc  input  XLEN  upstream PC
up_pc_next  input  XLEN  upstream next PC
up_instr  input  ILEN  upstream instruction
dn_valid  output  1  downstream beat valid
dn_ready  input  1  downstream accepts beat
dn_pc  output  XLEN  held PC
dn_pc_next  output  XLEN  held next PC
dn_instr  output  ILEN  held instruction, NOP_INSTR when dn_valid=0
occupancy  output  2  beats held: 0, 1 or 2

Behaviour:
- Storage: main register (drives dn_*) and skid register. Outputs come directly from flops; no combinational path from up_* to dn_* or from dn_ready to up_ready.
- up_ready = !skid_valid (registered). Upstream transfer = up_valid & up_ready. Downstream transfer = dn_valid & dn_ready.
- States: EMPTY (occ 0), FULL (main valid, occ 1), SKID (both valid, occ 2).
- EMPTY: up transfer → FULL, main loads up_*.
- FULL: up only → SKID if !dn_ready (skid loads up_*); up + dn transfer → stay FULL, main loads up_*; dn only → EMPTY; neither → hold.
- SKID: up_ready=0. dn transfer → FULL, main loads skid contents; otherwise hold.
- Order is strictly preserved; each beat is delivered exactly once.
- No-beat bubble: whenever dn_valid=0, dn_instr = NOP_INSTR. dn_pc/dn_pc_next hold their last values.
- Flush: if flush_i=1 at an edge, next state = EMPTY, occupancy=0, up_ready=1 and dn_instr=NOP_INSTR; any same-cycle upstream beat is dropped. Flush overrides all other events, including a simultaneous dn transfer; the downstream consumer must treat a beat presented on the flush cycle as sampled.
- Stall: dn_ready held 0 → at most 2 beats accepted, then up_ready=0 until space frees. dn_* remain stable while dn_valid=1 & dn_ready=0.
- Reset (asserted asynchronously at any time, including mid-transfer): dn_valid=0, up_ready=1, occupancy=0, dn_pc=dn_pc_next=RESET_PC, dn_instr=NOP_INSTR, skid contents cleared to the same values. Counters, if present, are cleared to 0. Release is synchronised by the system; the block accepts a beat on the first edge after rst goes high.
- Throughput: 1 beat/cycle sustained when dn_ready=1. Latency: 1 cycle from up transfer to dn_valid.

Optional Feature:
PIPE_STAGE_PERF_EN. Defined: adds outputs stall_cnt[31:0] (increments each cycle dn_valid & !dn_ready) and flush_cnt[31:0] (increments each cycle flush_i=1 with occupancy>0). Both counters saturate at 32'hFFFF_FFFF and reset to 0. Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then stream: rst low→high, dn_ready=1, drive pc=0x00,0x04,0x08 with instr 0xA,0xB,0xC on consecutive cycles → dn_valid goes high 1 cycle later, same order and values, up_ready stays 1, occupancy=1.
- Backpressure: dn_ready=0, drive 3 beats pc=0x10,0x14,0x18 → occupancy 1 then 2, up_ready=0 after the second beat, third beat held upstream; dn_ready=1 → 0x10,0x14,0x18 delivered in order with no loss.
- Flush with both entries full: occupancy=2, flush_i=1 with up_valid=1 pc=0x20 → next cycle dn_valid=0, dn_instr=0x00000013, occupancy=0, pc 0x20 never appears.
- Simultaneous in/out in FULL: dn_ready=1, up_valid=1 each cycle for 8 cycles → occupancy remains 1, zero bubbles, up_ready=1 throughout.
- Async reset mid-stall: occupancy=2, assert rst between clock edges → outputs reach reset values immediately (dn_valid=0, dn_pc=RESET_PC), with no dependence on clk.
- PIPE_STAGE_PERF_EN: 5 cycles of dn_valid=1, dn_ready=0, then a flush → stall_cnt=5, flush_cnt=1. Preload stall_cnt near max → saturates at 0xFFFFFFFF.
